// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and credit sizing for the instruction-fetch stage
package if_pkg;
  localparam int IF_ADDR_W = 32;
  localparam int IF_INST_W = 32;
  localparam int IF_DEPTH  = 4;
  localparam int IF_CRED_W = $clog2(IF_DEPTH) + 1;

  typedef enum logic {
    FS_RUN   = 1'b0,
    FS_FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [IF_INST_W-1:0] inst;
  } if_entry_t;

  // Counters must hold the value DEPTH itself, hence the extra bit.
  function automatic int if_cred_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - registered prefetch queue with push/pop/clear and occupancy count
module if_fifo
  import if_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int CNT_W = if_cred_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = pop && (r_count != '0);
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_do_push = push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !clr) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
endmodule

// File: rtl/stage_if_prefetch.sv
// rtl/stage_if_prefetch.sv - fetch stage: PC/credit/discard tracking, prefetch queue, redirect flush
// Optional IF_PERF_CNT_EN adds saturating fetch_cnt/stall_cnt outputs.
module stage_if_prefetch
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              freeze,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] instruction,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt,
`endif
  output logic [ADDR_W-1:0] pc
);
  localparam int                CNT_W = if_cred_w(DEPTH);
  localparam int                ENT_W = ADDR_W + INST_W;
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_discard;
  logic [CNT_W-1:0]  w_discard_nxt;
  logic [CNT_W-1:0]  w_q_count;
  logic [ENT_W-1:0]  w_din;
  logic [ENT_W-1:0]  w_dout;
  entry_t            w_head;
  logic              w_fire;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;

  // Queued plus in-flight never exceeds DEPTH, so every response has a slot.
  assign imem_req  = !rst && !branch_taken &&
                     (({1'b0, w_q_count} + {1'b0, r_outstanding}) < (CNT_W+1)'(DEPTH));
  assign imem_addr = r_fetch_pc;
  assign w_fire    = imem_req && imem_gnt;

  always_comb begin
    w_discard_nxt = r_discard;
    if (branch_taken)
      w_discard_nxt = r_outstanding - CNT_W'(imem_rvalid);
    else if (imem_rvalid && w_drop)
      w_discard_nxt = r_discard - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FS_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = (w_discard_nxt != '0) ? FS_FLUSH : FS_RUN;
  end

  always_comb begin
    w_drop = (r_state == FS_FLUSH);
    w_push = imem_rvalid && !w_drop && !branch_taken;
    w_pop  = inst_valid && !freeze && !branch_taken;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_discard     <= w_discard_nxt;
      r_outstanding <= r_outstanding + CNT_W'(w_fire) - CNT_W'(imem_rvalid);
      if (branch_taken) begin
        r_fetch_pc <= branch_addr;
        r_resp_pc  <= branch_addr;
      end else begin
        if (w_fire) r_fetch_pc <= r_fetch_pc + STEP;
        if (w_push) r_resp_pc  <= r_resp_pc + STEP;
      end
    end
  end

  assign w_din = {r_resp_pc, imem_rdata};

  if_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (branch_taken),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .count (w_q_count)
  );

  assign w_head      = w_dout;
  assign inst_valid  = (w_q_count != '0);
  assign instruction = inst_valid ? w_head.inst : '0;
  assign pc          = inst_valid ? (w_head.pc + STEP) : '0;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop && (r_fetch_cnt != '1)) r_fetch_cnt <= r_fetch_cnt + 1'b1;
      if (!inst_valid && !freeze && !branch_taken && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

  rvalid_needs_credit: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (r_outstanding != '0));
endmodule

// File: tb/tb_stage_if_prefetch.sv
// tb/tb_stage_if_prefetch.sv - directed table-driven bench for stage_if_prefetch
module tb_stage_if_prefetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        freeze = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  stage_if_prefetch #(
    .ADDR_W   (32),
    .INST_W   (32),
    .DEPTH    (4),
    .PC_STEP  (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .freeze       (freeze),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .instruction  (instruction),
`ifdef IF_PERF_CNT_EN
    .fetch_cnt    (fetch_cnt),
    .stall_cnt    (stall_cnt),
`endif
    .pc           (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          br;
    logic [31:0] ba;
    bit          frz;
    bit          gnt;
    bit          rv;
    logic [31:0] ra;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_iv;
    logic [31:0] e_head;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'hA5C3_0000 ^ a;
  endfunction

  function automatic vec_t v(input bit br, input logic [31:0] ba, input bit frz, input bit gnt,
                             input bit rv, input logic [31:0] ra, input bit e_req,
                             input logic [31:0] e_addr, input bit e_iv, input logic [31:0] e_head);
    vec_t r;
    r.br = br; r.ba = ba; r.frz = frz; r.gnt = gnt; r.rv = rv; r.ra = ra;
    r.e_req = e_req; r.e_addr = e_addr; r.e_iv = e_iv; r.e_head = e_head;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t x);
    branch_taken = x.br;
    branch_addr  = x.ba;
    freeze       = x.frz;
    imem_gnt     = x.gnt;
    imem_rvalid  = x.rv;
    imem_rdata   = x.rv ? dat(x.ra) : 32'h0;
  endtask

  task automatic idle();
    branch_taken = 1'b0;
    branch_addr  = '0;
    freeze       = 1'b0;
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;
  endtask

  initial begin
    int exp_fetch;
    int exp_stall;
    exp_fetch = 0;
    exp_stall = 0;

    // streaming with gnt=1 and rvalid one cycle after gnt
    vecs.push_back(v(0, 0, 0, 1, 0, 0,      1, 32'h00, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h00, 1, 32'h04, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h04, 1, 32'h08, 1, 32'h00));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h08, 1, 32'h0C, 1, 32'h04));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h0C, 1, 32'h10, 1, 32'h08));
    vecs.push_back(v(0, 0, 0, 0, 1, 32'h10, 1, 32'h14, 1, 32'h0C));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,      1, 32'h14, 1, 32'h10));
    // grant withheld: request and address hold
    for (int k = 0; k < 5; k++) vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h14, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0,      1, 32'h14, 0, 0));
    // freeze fills the queue to DEPTH, then drains without gaps
    vecs.push_back(v(0, 0, 1, 1, 1, 32'h14, 1, 32'h18, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 1, 32'h18, 1, 32'h1C, 1, 32'h14));
    vecs.push_back(v(0, 0, 1, 1, 1, 32'h1C, 1, 32'h20, 1, 32'h14));
    vecs.push_back(v(0, 0, 1, 1, 1, 32'h20, 0, 32'h24, 1, 32'h14));
    for (int k = 0; k < 5; k++) vecs.push_back(v(0, 0, 1, 1, 0, 0, 0, 32'h24, 1, 32'h14));
    vecs.push_back(v(0, 0, 0, 1, 0, 0,      0, 32'h24, 1, 32'h14));
    vecs.push_back(v(0, 0, 0, 1, 0, 0,      1, 32'h24, 1, 32'h18));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h24, 1, 32'h28, 1, 32'h1C));
    vecs.push_back(v(0, 0, 0, 0, 1, 32'h28, 1, 32'h2C, 1, 32'h20));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,      1, 32'h2C, 1, 32'h24));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,      1, 32'h2C, 1, 32'h28));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,      1, 32'h2C, 0, 0));
    // three outstanding, redirect to 0x100
    vecs.push_back(v(0, 0, 0, 1, 0, 0,      1, 32'h2C, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0,      1, 32'h30, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0,      1, 32'h34, 0, 0));
    vecs.push_back(v(1, 32'h100, 0, 1, 1, 32'h2C, 0, 32'h38, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h30,  1, 32'h100, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h34,  1, 32'h104, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 32'h100, 1, 32'h108, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 32'h104, 1, 32'h108, 1, 32'h100));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,       1, 32'h108, 1, 32'h104));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,       1, 32'h108, 0, 0));
    // branch with rvalid under freeze, then a second branch the next cycle
    vecs.push_back(v(0, 0, 0, 1, 0, 0,       1, 32'h108, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h108, 1, 32'h10C, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 0,       1, 32'h110, 1, 32'h108));
    vecs.push_back(v(1, 32'h180, 1, 1, 1, 32'h10C, 0, 32'h114, 1, 32'h108));
    vecs.push_back(v(1, 32'h200, 1, 1, 0, 0,       0, 32'h180, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h110, 1, 32'h200, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 32'h200, 1, 32'h204, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,       1, 32'h204, 1, 32'h200));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,       1, 32'h204, 0, 0));

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req",  32'(imem_req), 0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_iv",   32'(inst_valid), 0);
    chk("reset_inst", instruction, 32'h0);
    chk("reset_pc",   pc, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      @(negedge clk);
      chk($sformatf("r%0d_req", i),  32'(imem_req), 32'(vecs[i].e_req));
      chk($sformatf("r%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("r%0d_iv", i),   32'(inst_valid), 32'(vecs[i].e_iv));
      chk($sformatf("r%0d_inst", i), instruction, vecs[i].e_iv ? dat(vecs[i].e_head) : 32'h0);
      chk($sformatf("r%0d_pc", i),   pc, vecs[i].e_iv ? vecs[i].e_head + 32'h4 : 32'h0);
      if (!vecs[i].br && !vecs[i].frz) begin
        if (vecs[i].e_iv) exp_fetch++;
        else              exp_stall++;
      end
      @(posedge clk);
      #1;
    end
    idle();
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch_cnt", fetch_cnt, 32'(exp_fetch));
    chk("perf_stall_cnt", stall_cnt, 32'(exp_stall));
`endif

    // reset pulsed with an instruction queued
    imem_gnt = 1'b1;
    @(posedge clk);
    #1 imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = dat(32'h204);
    @(posedge clk);
    #1 imem_rvalid = 1'b0;
    chk("prerst_iv",   32'(inst_valid), 1);
    chk("prerst_inst", instruction, dat(32'h204));
    #2 rst = 1'b1;
    #1;
    chk("midrst_req",  32'(imem_req), 0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_iv",   32'(inst_valid), 0);
    chk("midrst_inst", instruction, 32'h0);
    chk("midrst_pc",   pc, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    imem_gnt = 1'b1;
    @(negedge clk);
    chk("restart_req",  32'(imem_req), 1);
    chk("restart_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1 imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = dat(32'h0);
    chk("restart_addr2", imem_addr, 32'h4);
    @(posedge clk);
    #1 imem_rvalid = 1'b0;
    chk("restart_iv",   32'(inst_valid), 1);
    chk("restart_inst", instruction, dat(32'h0));
    chk("restart_pc",   pc, 32'h4);

    // redirect to the top of the address space; pc and fetch address wrap
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("wrap_br_req", 32'(imem_req), 0);
    @(posedge clk);
    #1 branch_taken = 1'b0;
    branch_addr = '0;
    imem_gnt    = 1'b1;
    chk("wrap_flushed_iv", 32'(inst_valid), 0);
    @(negedge clk);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    @(posedge clk);
    #1 imem_gnt = 1'b0;
    chk("wrap_addr_next", imem_addr, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = dat(32'hFFFF_FFFC);
    @(posedge clk);
    #1 imem_rvalid = 1'b0;
    chk("wrap_iv",   32'(inst_valid), 1);
    chk("wrap_inst", instruction, dat(32'hFFFF_FFFC));
    chk("wrap_pc",   pc, 32'h0);
    @(posedge clk);
    #1;
    chk("wrap_drained_iv", 32'(inst_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
